fifo_rd_stream: RTL
===================

// Module: fifo_rd_stream
// PURPOSE
//  Read-side consumer for async_fifo in the rd_clk domain.
//  - Drives the FIFO's rd_en/rd_data/empty port (registered read: data one cycle after rd_en).
//  - Re-presents the words as a valid/ready stream, sustaining one word per cycle.
//  - m_ready has no combinational path to fifo_rd_en.
//  - Counts delivered beats.
// PARAMETERS
//  DW  8   data width; matches async_fifo DW
//  CW  16  beat counter width
// PORTS
//  rd_clk        in   1    clock (async_fifo read clock)
//  rd_reset_n    in   1    reset, synchronous, active-low
//  fifo_empty    in   1    async_fifo empty
//  fifo_rd_en    out  1    async_fifo rd_en
//  fifo_rd_data  in   DW   async_fifo rd_data; valid the cycle after fifo_rd_en
//  m_valid       out  1    stream word available
//  m_data        out  DW   stream word
//  m_ready       in   1    sink accepts; handshake = m_valid & m_ready
//  beat_cnt      out  CW   handshakes since reset, wraps at 2**CW
//  buf_level     out  2    words held in output buffer, 0..3
// BEHAVIOUR
//  Reset (rd_reset_n=0 at posedge rd_clk):
//  - m_valid=0, m_data=0, beat_cnt=0, buf_level=0, fifo_rd_en=0.
//  - inflight flag cleared; buffer pointers=0; entries cleared to 0.
//  Internal state:
//  - 3-entry buffer (BUF_DEPTH=3) with head/tail pointers.
//  - inflight: registered copy of fifo_rd_en.
//  fifo_rd_en (combinational from registered state and fifo_empty only):
//  - fifo_rd_en = rd_reset_n & ~fifo_empty & (buf_level + inflight < 3).
//  - Never asserted while fifo_empty=1.
//  Push: inflight=1 -> fifo_rd_data written at tail; tail wraps 2->0.
//  Pop: m_valid & m_ready -> head advances with the same wrap; beat_cnt+1, modulo 2**CW.
//  Simultaneous push and pop: buf_level unchanged; both pointers advance.
//  buf_level: registered; +1 on push only, -1 on pop only.
//  Credit rule: buf_level+inflight <= 3 always, so a push never overflows the buffer.
//  m_valid = (buf_level != 0); m_data = entry at head.
//  - Both derived from registered state; no bypass from fifo_rd_data.
//  AXI-style hold: while m_valid & ~m_ready, m_valid and m_data stay stable.
//  Latency:
//  - fifo_rd_en at cycle t -> word in buffer at t+2, m_valid=1 at t+2.
//  - Empty-to-first-word latency is 2 cycles.
//  Throughput with m_ready held at 1: steady state has buf_level=1, inflight=1 -> one beat per cycle.
//  Sink stall:
//  - buffer fills to 3 and fifo_rd_en drops;
//  - reads resume the cycle after buf_level+inflight < 3.
//  FIFO empties mid-stream: buffered words still drain; m_valid drops after the last pop.
//  Reset mid-operation:
//  - an inflight word and all buffered words are discarded;
//  - FIFO pointers have already advanced for those words, so they are lost;
//  - system asserts rd_reset_n together with the async_fifo read reset.
//  buf_level never exceeds 3; pop is never taken with buf_level=0.
// STRUCTURE
//  Package fifo_rd_pkg:
//  - localparam BUF_DEPTH=3, LVL_W=2;
//  - typedef logic [LVL_W-1:0] lvl_t (buf_level, pointers).
//  Sub-module fifo_rd_skid_buf:
//  - 3-entry circular buffer with push/pop/level, parameter DW;
//  - top holds the inflight flag, credit logic and beat counter.
// TESTING
//  - Reset: hold rd_reset_n=0 for 5 cycles with fifo_empty=0
//    -> fifo_rd_en=0, m_valid=0, beat_cnt=0, buf_level=0 throughout.
//  - Single word: fifo_empty=0 for one cycle, word 8'h06, m_ready=1
//    -> fifo_rd_en 1 cycle; m_valid at +2 with m_data=8'h06; beat_cnt=1.
//  - Streaming: FIFO preloaded 6..205, m_ready=1
//    -> 200 consecutive beats 6..205 in order, no bubbles after the first, beat_cnt=200.
//  - Backpressure: m_ready=0 with FIFO non-empty
//    -> exactly 3 reads, buf_level=3, fifo_rd_en=0;
//    -> m_data held; after m_ready=1, data in order with no loss/dup.
//  - Random m_ready (50%) plus random FIFO fill
//    -> scoreboard order match; fifo_rd_en never while empty; buf_level<=3.
//  - Reset mid-stream with buf_level=2, inflight=1
//    -> next cycle m_valid=0, buf_level=0, beat_cnt=0;
//    -> streaming resumes from the next FIFO word; CW=4 run shows beat_cnt wrap 15->0.

Source files
------------

// File: rtl/fifo_rd_pkg.sv
// Shared definitions for the async_fifo read-side stream consumer.
//   BUF_DEPTH : entries in the output buffer
//   LVL_W     : width of buffer level and pointers
//   lvl_t     : type used for buffer level and head/tail pointers
//   ptr_inc   : circular pointer increment, wraps BUF_DEPTH-1 -> 0
package fifo_rd_pkg;

  localparam int BUF_DEPTH = 3;
  localparam int LVL_W     = 2;

  typedef logic [LVL_W-1:0] lvl_t;

  function automatic lvl_t ptr_inc(input lvl_t p);
    return (p == lvl_t'(BUF_DEPTH - 1)) ? '0 : lvl_t'(p + 1'b1);
  endfunction

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Three-entry circular output buffer for fifo_rd_stream.
// Ports:
//   clk_i    in   clock
//   rst_ni   in   synchronous active-low reset
//   push_i   in   write data_i at tail
//   data_i   in   DW  word to write
//   pop_i    in   advance head (caller guarantees level_o != 0)
//   level_o  out  words held, 0..BUF_DEPTH
//   data_o   out  DW  word at head
module fifo_rd_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic          pop_i,
  output lvl_t          level_o,
  output logic [DW-1:0] data_o
);

  logic [DW-1:0] mem_q [BUF_DEPTH];
  logic [DW-1:0] mem_d [BUF_DEPTH];
  lvl_t          head_q, head_d;
  lvl_t          tail_q, tail_d;
  lvl_t          level_q, level_d;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    level_d = level_q;
    if (push_i) begin
      mem_d[tail_q] = data_i;
      tail_d        = ptr_inc(tail_q);
    end
    if (pop_i) begin
      head_d = ptr_inc(head_q);
    end
    // Simultaneous push and pop leaves the level unchanged.
    case ({push_i, pop_i})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_q   <= '{default: '0};
      head_q  <= '0;
      tail_q  <= '0;
      level_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      level_q <= level_d;
    end
  end

  assign level_o = level_q;
  assign data_o  = mem_q[head_q];

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side consumer for async_fifo: issues registered reads and re-presents
// the words as a valid/ready stream at one word per cycle, counting beats.
// Ports:
//   rd_clk        in   async_fifo read clock
//   rd_reset_n    in   synchronous active-low reset
//   fifo_empty    in   async_fifo empty
//   fifo_rd_en    out  async_fifo read enable
//   fifo_rd_data  in   DW  read data, valid the cycle after fifo_rd_en
//   m_valid       out  stream word available
//   m_data        out  DW  stream word
//   m_ready       in   sink accepts
//   beat_cnt      out  CW  handshakes since reset, wrapping
//   buf_level     out  words held in the output buffer
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int DW = 8,
  parameter int CW = 16
) (
  input  logic          rd_clk,
  input  logic          rd_reset_n,
  input  logic          fifo_empty,
  output logic          fifo_rd_en,
  input  logic [DW-1:0] fifo_rd_data,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  input  logic          m_ready,
  output logic [CW-1:0] beat_cnt,
  output logic [1:0]    buf_level
);

  logic          inflight_q;
  logic [CW-1:0] beat_q, beat_d;
  lvl_t          level;
  logic [LVL_W:0] credit_used;
  logic          pop;

  // Credits count buffered words plus the one still on its way from the FIFO,
  // so a read is only issued when its word is guaranteed a free slot. This
  // keeps m_ready out of the fifo_rd_en path entirely.
  assign credit_used = {1'b0, level} + {{LVL_W{1'b0}}, inflight_q};
  assign fifo_rd_en  = rd_reset_n & ~fifo_empty
                     & (credit_used < (LVL_W+1)'(BUF_DEPTH));

  assign m_valid = (level != '0);
  assign pop     = m_valid & m_ready;
  assign beat_d  = pop ? beat_q + CW'(1) : beat_q;

  always_ff @(posedge rd_clk) begin
    if (!rd_reset_n) begin
      inflight_q <= 1'b0;
      beat_q     <= '0;
    end else begin
      inflight_q <= fifo_rd_en;
      beat_q     <= beat_d;
    end
  end

  fifo_rd_skid_buf #(
    .DW(DW)
  ) u_buf (
    .clk_i  (rd_clk),
    .rst_ni (rd_reset_n),
    .push_i (inflight_q),
    .data_i (fifo_rd_data),
    .pop_i  (pop),
    .level_o(level),
    .data_o (m_data)
  );

  assign beat_cnt  = beat_q;
  assign buf_level = level;

endmodule
